// File: rtl/houghlines_accel_sdiv_26s_10s_16_seq.sv
// Sequential radix-2 restoring signed divider, 26s / 10s -> 16s quotient, 10s remainder.
// Optional macro HOUGHLINES_SDIV_SAT_EN saturates the quotient on overflow instead of wrapping.
module houghlines_accel_sdiv_26s_10s_16_seq #(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = 26,
  parameter int DIVISOR_W  = 10,
  parameter int QUOT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  ready,
  output logic                  dout_valid,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  dz,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [4:0]  count;
  logic [25:0] dvd;
  logic [25:0] q_mag;
  logic [10:0] div;
  logic [10:0] pr;
  logic        sign_q;
  logic        sign_r;
  logic        zero_div;

  logic        accept;
  logic [25:0] abs0;
  logic [10:0] din1_x;
  logic [10:0] abs1;
  logic [10:0] shifted;
  logic [10:0] diff;
  logic        ge;
  logic signed [27:0] q_pos;
  logic signed [27:0] q_full;
  logic [9:0]  r_mag;
  logic [9:0]  rem_c;
  logic        ovf_c;
  logic [15:0] quot_c;

  logic unused_id;
  assign unused_id = ^ID;

  assign accept = ce && start && (state == IDLE);
  assign ready  = (state == IDLE);

  // Magnitudes of the operands; the divisor gets an extra bit so -512 becomes +512.
  always_comb begin
    din1_x = {din1[9], din1};
    abs0   = din0[25] ? (~din0 + 26'd1) : din0;
    abs1   = din1[9] ? (~din1_x + 11'd1) : din1_x;
  end

  // One restoring step: bring in the next dividend bit and subtract if it fits.
  always_comb begin
    shifted = {pr[9:0], dvd[25]};
    ge      = (shifted >= div);
    diff    = shifted - div;
  end

  // Sign fix-up, overflow detection and the final quotient selection.
  always_comb begin
    q_pos  = $signed({2'b00, q_mag});
    q_full = sign_q ? -q_pos : q_pos;
    r_mag  = pr[9:0];
    rem_c  = sign_r ? (~r_mag + 10'd1) : r_mag;
    ovf_c  = (q_full > 28'sd32767) || (q_full < -28'sd32768);
`ifdef HOUGHLINES_SDIV_SAT_EN
    if (ovf_c)
      quot_c = q_full[27] ? 16'h8000 : 16'h7FFF;
    else
      quot_c = q_full[15:0];
`else
    quot_c = q_full[15:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ce) begin
      case (state)
        IDLE:    if (start) state_next = CALC;
        CALC:    if (count == 5'd25) state_next = FIX;
        FIX:     state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 5'd0;
      dvd        <= 26'd0;
      q_mag      <= 26'd0;
      div        <= 11'd0;
      pr         <= 11'd0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      zero_div   <= 1'b0;
      dout_valid <= 1'b0;
      quot       <= 16'd0;
      rem        <= 10'd0;
      dz         <= 1'b0;
      ovf        <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q   <= din0[25] ^ din1[9];
            sign_r   <= din0[25];
            zero_div <= (din1 == 10'd0);
            dvd      <= abs0;
            div      <= abs1;
            pr       <= 11'd0;
            q_mag    <= 26'd0;
            count    <= 5'd0;
          end
        end
        CALC: begin
          pr    <= ge ? diff : shifted;
          dvd   <= {dvd[24:0], 1'b0};
          q_mag <= {q_mag[24:0], ge};
          count <= count + 5'd1;
        end
        FIX: begin
          dout_valid <= 1'b1;
          dz         <= zero_div;
          if (zero_div) begin
            quot <= sign_r ? 16'h8000 : 16'h7FFF;
            rem  <= 10'd0;
            ovf  <= 1'b0;
          end else begin
            quot <= quot_c;
            rem  <= rem_c;
            ovf  <= ovf_c;
          end
        end
        DONE: begin
          dout_valid <= 1'b0;
        end
        default: begin
          dout_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_houghlines_accel_sdiv_26s_10s_16_seq.sv
// Self-checking bench for the sequential signed divider, using a plain integer reference model.
module tb_houghlines_accel_sdiv_26s_10s_16_seq;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ce = 1'b1;
  logic              start = 1'b0;
  logic signed [25:0] din0 = '0;
  logic signed [9:0]  din1 = '0;
  logic              ready;
  logic              dout_valid;
  logic [15:0]       quot;
  logic [9:0]        rem;
  logic              dz;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  houghlines_accel_sdiv_26s_10s_16_seq #(.ID(1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .start(start),
    .din0(din0), .din1(din1),
    .ready(ready), .dout_valid(dout_valid),
    .quot(quot), .rem(rem), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // C-semantics division using native integer arithmetic.
  function automatic void model(input longint a, input longint b,
                                output logic [15:0] q, output logic [9:0] r,
                                output logic z, output logic o);
    longint qf, rf;
    if (b == 0) begin
      z = 1'b1; o = 1'b0; r = 10'd0;
      q = (a >= 0) ? 16'h7FFF : 16'h8000;
    end else begin
      qf = a / b;
      rf = a % b;
      z = 1'b0;
      o = (qf > 32767) || (qf < -32768);
      q = qf[15:0];
`ifdef HOUGHLINES_SDIV_SAT_EN
      if (o) q = (qf < 0) ? 16'h8000 : 16'h7FFF;
`endif
      r = rf[9:0];
    end
  endfunction

  task automatic run_div(input logic signed [25:0] a, input logic signed [9:0] b,
                         input int stall_at, input int stall_len,
                         output bit got, output int edges, output logic valid_after);
    int w;
    w = 0;
    while (!ready && w < 60) begin @(posedge clk); #1; w++; end
    din0 = a; din1 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 0; got = 1'b0;
    while (!got && edges < 100) begin
      if (edges == stall_at) ce = 1'b0;
      if (edges == stall_at + stall_len) ce = 1'b1;
      @(posedge clk); #1;
      edges++;
      got = dout_valid;
    end
    ce = 1'b1;
    valid_after = 1'bx;
    if (got) begin @(posedge clk); #1; valid_after = dout_valid; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", dout_valid); end
    checks++; if (quot !== 16'd0) begin errors++; $display("[TB] FAIL reset_quot got=%h exp=0", quot); end
    checks++; if (rem !== 10'd0) begin errors++; $display("[TB] FAIL reset_rem got=%h exp=0", rem); end
    checks++; if ({dz, ovf} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got=%b%b exp=00", dz, ovf); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic signed [25:0] ta [12];
    logic signed [9:0]  tb [12];
    logic [15:0] eq; logic [9:0] er; logic ez, eo;
    bit got; int edges; logic va;
    ta = '{26'sd1000, -26'sd1000, 26'sd1000, -26'sd1000, -26'sd33554432, 26'sd33554431,
           -26'sd33554432, -26'sd32768, 26'sd32768, 26'sd12345, -26'sd5, 26'sd777};
    tb = '{10'sd7, 10'sd7, -10'sd7, -10'sd7, -10'sd1, 10'sd1,
           10'sd1, 10'sd1, 10'sd1, 10'sd0, 10'sd0, -10'sd512};
    for (int i = 0; i < 12; i++) begin
      model(longint'(ta[i]), longint'(tb[i]), eq, er, ez, eo);
      run_div(ta[i], tb[i], -1, 0, got, edges, va);
      checks++; if (!got || edges != 27) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d exp=27 valid=%b", i, edges, got); end
      checks++; if (va !== 1'b0) begin errors++; $display("[TB] FAIL dir%0d_pulse valid_next=%b exp=0", i, va); end
      checks++; if (quot !== eq) begin errors++; $display("[TB] FAIL dir%0d_quot %0d/%0d got=%h exp=%h", i, ta[i], tb[i], quot, eq); end
      checks++; if (rem !== er) begin errors++; $display("[TB] FAIL dir%0d_rem got=%h exp=%h", i, rem, er); end
      checks++; if ({dz, ovf} !== {ez, eo}) begin errors++; $display("[TB] FAIL dir%0d_flags got=%b%b exp=%b%b", i, dz, ovf, ez, eo); end
      if (i == 0) begin
        checks++; if (quot !== 16'd142 || rem !== 10'd6) begin errors++; $display("[TB] FAIL basic_1000_7 got=%0d,%0d exp=142,6", quot, rem); end
      end
    end
  endtask

  task automatic test_ce_stall();
    bit got; int edges; logic va;
    run_div(26'sd100, 10'sd3, 10, 5, got, edges, va);
    checks++; if (!got || edges != 32) begin errors++; $display("[TB] FAIL stall_latency got=%0d exp=32 valid=%b", edges, got); end
    checks++; if (quot !== 16'd33 || rem !== 10'd1) begin errors++; $display("[TB] FAIL stall_result got=%0d,%0d exp=33,1", quot, rem); end
  endtask

  task automatic test_reset_mid();
    bit got; int edges; logic va;
    bit seen;
    run_div(26'sd1000, 10'sd7, -1, 0, got, edges, va);
    din0 = 26'sd100; din1 = 10'sd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    checks++; if (quot !== 16'd0 || rem !== 10'd0 || dz !== 1'b0 || ovf !== 1'b0)
      begin errors++; $display("[TB] FAIL midreset_outputs got=%h,%h,%b,%b exp=0", quot, rem, dz, ovf); end
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (dout_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("[TB] FAIL midreset_novalid got=1 exp=0"); end
    checks++; if (ready !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready got=%b exp=1", ready); end
  endtask

  task automatic test_random();
    logic signed [25:0] a; logic signed [9:0] b;
    logic [15:0] eq; logic [9:0] er; logic ez, eo;
    bit got; int edges; logic va;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: a = 26'($urandom);
        1: a = 26'(signed'(16'($urandom)));
        2: a = 26'(signed'(20'($urandom)));
        default: a = 26'(signed'(8'($urandom)));
      endcase
      case ($urandom_range(0, 5))
        0: b = 10'sd0;
        1: b = -10'sd512;
        default: b = 10'($urandom);
      endcase
      model(longint'(a), longint'(b), eq, er, ez, eo);
      run_div(a, b, -1, 0, got, edges, va);
      checks++; if (!got || edges != 27) begin errors++; $display("[TB] FAIL rnd%0d_latency got=%0d exp=27", i, edges); end
      checks++; if ({quot, rem, dz, ovf} !== {eq, er, ez, eo})
        begin errors++; $display("[TB] FAIL rnd%0d %0d/%0d got=%h,%h,%b%b exp=%h,%h,%b%b", i, a, b, quot, rem, dz, ovf, eq, er, ez, eo); end
    end
  endtask

  task automatic test_back_to_back();
    logic signed [25:0] pa [2];
    logic signed [9:0]  pb [2];
    logic [15:0] mq; logic [9:0] mr; logic mz, mo;
    logic [29:0] exp_q [$];
    logic [29:0] cur;
    bit have;
    int nvalid, last;
    for (int k = 0; k < 2; k++) begin
      pa[k] = 26'(signed'(18'($urandom)));
      pb[k] = 10'($urandom_range(1, 500));
    end
    nvalid = 0; last = -1; have = 1'b0; cur = '0;
    while (!ready) begin @(posedge clk); #1; end
    start = 1'b1;
    for (int cyc = 0; cyc < 120; cyc++) begin
      din0 = pa[cyc % 2]; din1 = pb[cyc % 2];
      if (ready) begin
        model(longint'(din0), longint'(din1), mq, mr, mz, mo);
        exp_q.push_back({mq, mr, mz, mo});
      end
      @(posedge clk); #1;
      if (dout_valid) begin
        nvalid++;
        if (last >= 0) begin
          checks++; if (cyc - last != 29) begin errors++; $display("[TB] FAIL b2b_interval got=%0d exp=29", cyc - last); end
        end
        last = cyc;
        cur = (exp_q.size() > 0) ? exp_q.pop_front() : 30'h3FFFFFFF;
        have = 1'b1;
        checks++; if ({quot, rem, dz, ovf} !== cur) begin errors++; $display("[TB] FAIL b2b_result got=%h exp=%h", {quot, rem, dz, ovf}, cur); end
      end else if (have) begin
        checks++; if ({quot, rem, dz, ovf} !== cur) begin errors++; $display("[TB] FAIL b2b_hold cyc=%0d got=%h exp=%h", cyc, {quot, rem, dz, ovf}, cur); end
      end
    end
    start = 1'b0;
    checks++; if (nvalid != 4) begin errors++; $display("[TB] FAIL b2b_count got=%0d exp=4", nvalid); end
    repeat (35) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ce_stall();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/houghlines_accel_sdiv_26s_10s_16_seq.md
# houghlines_accel_sdiv_26s_10s_16_seq

Sequential signed divider for the Hough lines accelerator: the inverse of the 16s x 10s -> 26s DSP multiply path. It takes a 26-bit signed dividend and a 10-bit signed divisor and returns a 16-bit signed quotient plus a 10-bit signed remainder. It is used to rescale accumulated products back to coordinate precision, for example rho/scale and vote-normalisation. It uses a radix-2 iterative datapath with a start/ready/valid handshake and fixed latency.

## Interface
- ID, 1, instance identifier; no functional effect.
- DIVIDEND_W, 26, dividend width; fixed, other values unsupported.
- DIVISOR_W, 10, divisor width and remainder width; fixed.
- QUOT_W, 16, quotient output width; fixed.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable. When low, every register holds, including the FSM, counter and outputs.
- start  in  1  request. Accepted on a rising edge where ce=1, start=1 and ready=1.
- din0  in  26  signed dividend, sampled at accept.
- din1  in  10  signed divisor, sampled at accept.
- ready  out  1  high only in IDLE.
- dout_valid  out  1  one-ce-cycle pulse marking a new result.
- quot  out  16  signed quotient.
- rem  out  10  signed remainder.
- dz  out  1  divide-by-zero flag for the current result.
- ovf  out  1  quotient-overflow flag for the current result.

## Operation
- Reset state:
  - FSM=IDLE, ready=1.
  - dout_valid=0, quot=0, rem=0, dz=0, ovf=0.
  - Internal counter and working registers are all 0.
- IDLE:
  - On accept, latch sign_q = din0[25]^din1[9] and sign_r = din0[25].
  - Latch |din0| as 26-bit unsigned and |din1| as 10-bit unsigned; -512 maps to 512, so use an 11-bit internal divisor.
  - Set counter = 0 and go to CALC.
- CALC:
  - Each ce cycle performs one restoring step: shift the partial remainder left with the next dividend MSB, compare against the divisor, subtract when greater or equal, and shift the quotient bit in.
  - After 26 steps (counter reaches 25), go to FIX.
- FIX:
  - Apply signs: quot_full = sign_q ? -q : q, and rem = sign_r ? -r : r.
  - Division truncates toward zero; the remainder takes the sign of the dividend (C semantics).
  - Set ovf = (quot_full < -32768) || (quot_full > 32767).
  - Register the outputs, assert dout_valid and go to DONE.
- DONE: for one ce cycle dout_valid=1 and ready=0, then return to IDLE with dout_valid=0.
- Divide by zero (din1=0):
  - Follows the same state sequence and latency.
  - dz=1, ovf=0, rem=0.
  - quot = 0x7FFF if din0 >= 0, else 0x8000.
- Handshake rules:
  - start while ready=0 is ignored and is not queued.
  - quot, rem, dz and ovf hold their values until the next dout_valid.
- Reset mid-operation: asserting rst_n=0 in any state aborts the division. No dout_valid is produced and the block returns to the reset state.
- ce=0 during the DONE cycle holds dout_valid high until a ce=1 edge occurs.

## Timing
- Latency: an accept at ce-edge N produces dout_valid=1 after ce-edge N+27, i.e. 26 CALC cycles plus 1 FIX cycle. ce=0 cycles add to this latency one-for-one.
- Throughput: one division per 29 ce cycles (IDLE, 26 CALC, FIX, DONE). Back-to-back accept is possible in the first IDLE cycle after DONE.
- Outputs are driven from registers only; there are no combinational paths from input to output.
- ready is low from the edge after accept until the FSM re-enters IDLE.

## Configuration
- HOUGHLINES_SDIV_SAT_EN defined:
  - On ovf=1, quot saturates to 0x7FFF for positive overflow and 0x8000 for negative overflow.
- Not defined:
  - quot = quot_full[15:0], i.e. two's-complement wrap.
  - ovf is still reported.
  - Divide-by-zero output is unchanged in both builds.

## Test plan
- After reset, check the reset state: ready=1 and all outputs 0. Then accept 1000/7 -> after 27 ce-edges: dout_valid pulses for one cycle, quot=142, rem=6, dz=0, ovf=0.
- Sign cases, checking C-style truncation:
  - -1000/7 -> quot=-142, rem=-6.
  - 1000/-7 -> quot=-142, rem=6.
  - -1000/-7 -> quot=142, rem=-6.
- -33554432 / -1 -> ovf=1:
  - With SAT_EN: quot=0x7FFF.
  - Without: quot=0x0000.
  - In both builds: rem=0.
- Divide by zero:
  - 12345/0 -> dz=1, quot=0x7FFF, rem=0, at the same latency.
  - -5/0 -> quot=0x8000.
- ce stall and reset:
  - Drop ce for 5 cycles mid-CALC on 100/3 -> dout_valid arrives 5 cycles late with quot=33, rem=1.
  - Pulse rst_n low mid-CALC -> no dout_valid and outputs 0.
- start held high continuously with alternating operands:
  - Exactly one result per 29 cycles.
  - Starts issued while ready=0 are ignored.
  - Outputs hold their values between dout_valid pulses.
